// File: rtl/tone_clock_divider_if.sv
// Tone/timebase bus: tone setting in, step counter, strobe and buzzer drive out.
//   half_period : tone half-period in clk cycles, 0 = silence (master -> slave)
//   time_stamp  : slow step counter                           (slave -> master)
//   tick        : one-cycle strobe when time_stamp advances   (slave -> master)
//   sound       : square-wave buzzer drive                    (slave -> master)
interface tone_clock_divider_if #(
   parameter int unsigned STAMP_W = 4,
   parameter int unsigned TONE_W  = 22
);
   logic [TONE_W-1:0]  half_period;
   logic [STAMP_W-1:0] time_stamp;
   logic               tick;
   logic               sound;

   modport master (
      output half_period,
      input  time_stamp,
      input  tick,
      input  sound
   );

   modport slave (
      input  half_period,
      output time_stamp,
      output tick,
      output sound
   );
endinterface

// File: rtl/tone_clock_divider.sv
// Timebase and buzzer tone generator.
// Divides clk into a slow step counter (time_stamp) with a one-cycle tick
// strobe, and generates a 50% square wave whose half-period is set by
// half_period (0 silences the output).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tone_clock_divider_if slave (half_period in; time_stamp, tick, sound out)
module tone_clock_divider #(
   parameter int unsigned TICK_DIV = 27000000,
   parameter int unsigned STAMP_W  = 4,
   parameter int unsigned TONE_W   = 22
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tone_clock_divider_if.slave  bus
);

   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0]   div_cnt;
   logic [STAMP_W-1:0] time_stamp;
   logic               tick;
   logic [TONE_W-1:0]  tone_cnt;
   logic               sound;

   // Step divider: time_stamp advances and tick strobes when div_cnt wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         time_stamp <= '0;
         tick       <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt    <= '0;
         time_stamp <= time_stamp + STAMP_W'(1);
         tick       <= 1'b1;
      end else begin
         div_cnt    <= div_cnt + DIV_W'(1);
         tick       <= 1'b0;
      end
   end

   // Tone generator: >= compare so a shrinking half_period toggles at once
   // instead of running the counter up to its wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_cnt <= '0;
         sound    <= 1'b0;
      end else if (bus.half_period == '0) begin
         tone_cnt <= '0;
         sound    <= 1'b0;
      end else if (tone_cnt >= (bus.half_period - TONE_W'(1))) begin
         tone_cnt <= '0;
         sound    <= ~sound;
      end else begin
         tone_cnt <= tone_cnt + TONE_W'(1);
      end
   end

   assign bus.time_stamp = time_stamp;
   assign bus.tick       = tick;
   assign bus.sound      = sound;

endmodule

// File: tb/tb_tone_clock_divider.sv
// Randomized self-checking bench for tone_clock_divider with TICK_DIV=4.
// Reference model: time_stamp/tick derived arithmetically from the number of
// edges since reset release; sound tracked as "edges spent in the current
// half-period" against the half_period in force at each edge.
module tb_tone_clock_divider;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned STAMP_W  = 4;
   localparam int unsigned TONE_W   = 22;

   logic clk;
   logic rst_n;

   tone_clock_divider_if #(.STAMP_W(STAMP_W), .TONE_W(TONE_W)) bus ();

   tone_clock_divider #(
      .TICK_DIV (TICK_DIV),
      .STAMP_W  (STAMP_W),
      .TONE_W   (TONE_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // model state
   int edges   = 0;   // edges since reset release
   int in_half = 0;   // edges spent in current sound half-period
   bit m_sound = 1'b0;
   int tick_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      edges   = 0;
      in_half = 0;
      m_sound = 1'b0;
   endtask

   function automatic int exp_stamp();
      return (edges / TICK_DIV) % (1 << STAMP_W);
   endfunction

   function automatic bit exp_tick();
      return (edges > 0) && (edges % TICK_DIV == 0);
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".stamp"}, 32'(bus.time_stamp), 32'(exp_stamp()));
      check({tag, ".tick"},  32'(bus.tick),       32'(exp_tick()));
      check({tag, ".sound"}, 32'(bus.sound),      32'(m_sound));
   endtask

   // One clock edge: advance the model with the half_period seen at the edge,
   // then compare just after the edge.
   task automatic step(input string tag);
      int n;
      @(posedge clk);
      n = int'(bus.half_period);
      if (rst_n) begin
         edges++;
         if (n == 0) begin
            in_half = 0;
            m_sound = 1'b0;
         end else begin
            in_half++;
            if (in_half >= n) begin
               m_sound = ~m_sound;
               in_half = 0;
            end
         end
      end
      #1;
      if (bus.tick) tick_seen++;
      check_all(tag);
   endtask

   task automatic rand_hp();
      case ($urandom_range(0, 4))
         0:       bus.half_period = '0;
         1:       bus.half_period = TONE_W'(1);
         2:       bus.half_period = TONE_W'($urandom_range(2, 4));
         default: bus.half_period = TONE_W'($urandom_range(1, 20));
      endcase
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      bus.half_period = TONE_W'(3);
      model_reset();
      #12;
      check_all("reset");
      step("reset_hold");

      // wrap + steady tone at half_period=3
      #2 rst_n = 1'b1;
      tick_seen = 0;
      for (int i = 0; i < 64; i++) step("wrap");
      check("tick_count", 32'(tick_seen), 32'd16);

      // silence while sound high, then restart
      bus.half_period = TONE_W'(5);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step("sil_wait");
         if (m_sound) found = 1'b1;
      end
      check("sil_reached_high", 32'(found), 32'd1);
      bus.half_period = '0;
      for (int i = 0; i < 4; i++) step("silence");
      bus.half_period = TONE_W'(5);
      for (int i = 0; i < 12; i++) step("restart");

      // shrink mid-period: half_period 10, count at 7, switch to 4
      bus.half_period = TONE_W'(10);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step("shr_sync");
         if (in_half == 7) found = 1'b1;
      end
      check("shr_reached_7", 32'(found), 32'd1);
      bus.half_period = TONE_W'(4);
      for (int i = 0; i < 10; i++) step("shrink");

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      step("rst_hold");
      step("rst_hold");
      #2 rst_n = 1'b1;

      // random half_period activity during divider run
      tick_seen = 0;
      for (int i = 0; i < 300; i++) begin
         step("rand");
         if ($urandom_range(0, 3) == 0) rand_hp();
      end
      check("rand_tick_count", 32'(tick_seen), 32'(300 / TICK_DIV));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tone_clock_divider.md
Name: tone_clock_divider

Overview:
- Combined timebase and audio block for the LED/buzzer demo.
- Divides the system clock into a slow 4-bit step counter, `time_stamp`. Upstream logic uses `time_stamp` to index a tone table and drive LEDs.
- Also produces a square-wave `sound` output. The half-period of `sound`, in clock cycles, is set by the `half_period` input; a value of 0 silences the output.
- Sits directly between the board clock and the buzzer pin.

Parameters:
- TICK_DIV, 27000000: clock cycles per `time_stamp` step (1 Hz at 27 MHz); legal range 2 or more.
- STAMP_W, 4: width of `time_stamp`.
- TONE_W, 22: width of `half_period` and of the internal tone counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- half_period  input  TONE_W  tone half-period in clk cycles; 0 = silence.
- time_stamp  output  STAMP_W  slow step counter.
- tick  output  1  one-cycle strobe, high in the cycle `time_stamp` advances.
- sound  output  1  square-wave buzzer drive.

Behaviour:
- Reset (rst_n low, asynchronous): `time_stamp`=0, `tick`=0, `sound`=0, divider counter=0, tone counter=0. Outputs hold these values while rst_n is low.
- The first clock edge after rst_n rises counts as divider cycle 1.
- Divider:
  - The divider counter runs 0..TICK_DIV-1 and returns to 0 after TICK_DIV-1.
  - On the edge where it returns to 0, `time_stamp` increments and `tick` is registered high for exactly one cycle.
  - First `tick` and first `time_stamp` change occur TICK_DIV edges after reset release.
  - `time_stamp` wraps from 2^STAMP_W-1 to 0 with no stall.
- Tone generator, half_period = N > 0:
  - The tone counter increments each cycle.
  - When the counter is greater than or equal to N-1, it clears to 0 and `sound` toggles.
  - Result: `sound` period is 2N cycles at 50% duty. N=1 toggles every cycle.
- Tone generator, half_period = 0:
  - Tone counter is held at 0 and `sound` is forced to 0 on the next edge (registered, no glitch).
  - When `half_period` becomes nonzero again, counting restarts from 0 with `sound` low.
- Changing `half_period` mid-period:
  - The new value applies immediately; there is no wait for period end.
  - If the current count is already at or above newN-1, `sound` toggles on the next edge. Because of the greater-or-equal compare, shrinking N never causes a counter wrap.
- `half_period` is sampled every cycle and is assumed synchronous to clk.
- Divider and tone paths are independent; `half_period` changes never disturb `time_stamp`.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset mid-run: drive rst_n low asynchronously between edges -> `sound`, `time_stamp`, `tick` go to 0 immediately. After release with TICK_DIV=4, the first `tick` comes on edge 4 and `time_stamp`=1.
- Wrap: TICK_DIV=4, run 64 edges -> `time_stamp` steps 1..15 then 0. `tick` pulses exactly 16 times, each one cycle wide.
- Tone period: half_period=3 -> `sound` toggles every 3 edges (low 3, high 3). Measured period 6 cycles, duty 50%.
- Silence: half_period=5, switch to 0 while `sound` is high -> `sound`=0 on the next edge and stays 0. Switch back to 5 -> first rising edge of `sound` after 5 edges.
- Shrink mid-period: half_period=10, count reaches 7, change to 4 -> toggle on the next edge, then every 4 edges.
- Independence: toggle half_period randomly during a divider run -> `tick`/`time_stamp` timing identical to the undisturbed run.
